warmboot_sequencer: RTL and testbench
=====================================

# warmboot_sequencer

Controller that turns a bootloader "boot user image" request into a clean iCE40 warmboot. It sits between the bootloader core, the SPI flash engine, the USB pull-up pin and the SB_WARMBOOT primitive. It stalls and drains any in-flight SPI flash transaction and detaches from USB long enough for the host to register a disconnect. It then presents a stable image select to SB_WARMBOOT before asserting BOOT.

## Interface
Parameters:
- QUIESCE_CYCLES, 16: consecutive cycles with spi_busy low required before SPI is considered drained (≥1).
- DRAIN_TIMEOUT, 65536: maximum cycles spent in DRAIN before proceeding anyway (> QUIESCE_CYCLES).
- DETACH_CYCLES, 480000: cycles usb_pu is forced low (10 ms at 48 MHz) (≥1).
- ARM_CYCLES, 4: cycles wb_s1/wb_s0 are held stable with wb_boot low before firing (≥1).

Ports:
- clk_48mhz  in  1  system clock, 48 MHz from PLL
- reset  in  1  asynchronous, active-high reset
- boot_req  in  1  request to warmboot; sampled only in IDLE
- image_sel  in  2  {S1,S0} image index, latched with boot_req
- spi_busy  in  1  SPI flash engine has a transaction in progress
- spi_hold  out  1  forbids SPI engine from starting new transactions
- usb_pu_en  in  1  pull-up enable requested by USB core
- usb_pu  out  1  gated pull-up enable to pin
- wb_s1  out  1  to SB_WARMBOOT S1
- wb_s0  out  1  to SB_WARMBOOT S0
- wb_boot  out  1  to SB_WARMBOOT BOOT
- busy  out  1  sequencer not in IDLE
- drain_timeout  out  1  sticky: DRAIN exited by timeout

## Operation
- States: IDLE, DRAIN, DETACH, ARM, FIRE. One shared down/up counter, width sufficient for max(DRAIN_TIMEOUT, DETACH_CYCLES); separate quiet counter for QUIESCE_CYCLES.
- IDLE: boot_req=1 at a clock edge → DRAIN; image_sel latched into img register, counters cleared.
- DRAIN: quiet counter increments on each cycle with spi_busy=0 and clears to 0 on spi_busy=1. Exit to DETACH on the cycle that completes QUIESCE_CYCLES consecutive idle samples. Independently, after DRAIN_TIMEOUT cycles in DRAIN, exit to DETACH and set drain_timeout. If both occur on the same cycle, quiesce wins and drain_timeout stays 0.
- DETACH: exactly DETACH_CYCLES cycles, then → ARM.
- ARM: exactly ARM_CYCLES cycles, then → FIRE.
- FIRE: terminal; remains until reset (device reconfigures).
- Output decode (Moore, from registered state):
  - spi_hold=1 in DRAIN/DETACH/ARM/FIRE.
  - busy=1 in every state except IDLE.
  - usb_pu = usb_pu_en AND state∈{IDLE, DRAIN}.
  - wb_boot=1 only in FIRE.
  - {wb_s1,wb_s0}=img in all states.
- boot_req in any non-IDLE state is ignored; image_sel changes after latch are ignored.
- Reset (any time, including mid-DETACH or FIRE): immediately IDLE; img=00, counters=0, drain_timeout=0.

## Timing
- Reset values: spi_hold=0, busy=0, wb_boot=0, wb_s1=0, wb_s0=0, drain_timeout=0; usb_pu follows usb_pu_en.
- boot_req sampled at edge N → spi_hold=1 and busy=1 from cycle N+1.
- spi_busy already low and stays low: DETACH entered QUIESCE_CYCLES cycles after DRAIN entry.
- usb_pu low for exactly DETACH_CYCLES + ARM_CYCLES cycles before wb_boot, then stays low.
- wb_s1/wb_s0 stable ≥ARM_CYCLES+DETACH_CYCLES cycles before wb_boot rises; wb_boot is glitch-free (registered-state decode only).
- Best-case total latency boot_req → wb_boot: 1 + QUIESCE_CYCLES + DETACH_CYCLES + ARM_CYCLES cycles.

## Test plan
Bench uses QUIESCE_CYCLES=4, DRAIN_TIMEOUT=50, DETACH_CYCLES=100, ARM_CYCLES=4.
- Reset release, usb_pu_en=1, boot_req=0 for 200 cycles → all outputs at reset values, usb_pu=1, busy=0.
- boot_req pulse at cycle 10, image_sel=2'b10, spi_busy=0 → spi_hold/busy high at 11. usb_pu falls at 15 and stays low. wb_s1=1, wb_s0=0 from 11. wb_boot rises at 119 and stays high.
- spi_busy high for 7 cycles after request, then one glitch cycle high after 2 idle cycles → quiet count restarts. DETACH entered only after 4 consecutive idle cycles. drain_timeout=0.
- spi_busy stuck high → DETACH entered 50 cycles after DRAIN entry, drain_timeout=1, wb_boot still follows 104 cycles later.
- image_sel toggled and boot_req re-pulsed during DETACH → img and timing unchanged.
- reset asserted mid-DETACH (cycle 60 of 100) → same-instant return to reset values. A new boot_req afterward replays the full sequence with a freshly latched image.

Source files
------------

// File: rtl/warmboot_sequencer.sv
// Sequences a bootloader "boot user image" request into an iCE40 warmboot.
// Order: drain SPI, detach USB, hold a stable image select, then assert BOOT.
module warmboot_sequencer #(
    parameter int QUIESCE_CYCLES = 16,
    parameter int DRAIN_TIMEOUT  = 65536,
    parameter int DETACH_CYCLES  = 480000,
    parameter int ARM_CYCLES     = 4
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] image_sel,
    input  logic       spi_busy,
    output logic       spi_hold,
    input  logic       usb_pu_en,
    output logic       usb_pu,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy,
    output logic       drain_timeout
);

    localparam int CNT_MAX0 = (DRAIN_TIMEOUT > DETACH_CYCLES) ? DRAIN_TIMEOUT : DETACH_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > ARM_CYCLES) ? CNT_MAX0 : ARM_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int Q_W      = $clog2(QUIESCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_CYCLES - 1);
    localparam logic [Q_W-1:0]   QUIET_LAST  = Q_W'(QUIESCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_DETACH,
        S_ARM,
        S_FIRE
    } state_t;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [Q_W-1:0]   r_quiet, w_quiet_next;
    logic [1:0]       r_img, w_img_next;
    logic             r_dto, w_dto_next;
    logic             w_quiet_done, w_drain_expired;

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_quiet <= '0;
            r_img   <= 2'b00;
            r_dto   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_quiet <= w_quiet_next;
            r_img   <= w_img_next;
            r_dto   <= w_dto_next;
        end
    end

    // Quiesce is checked before the timeout so a same-cycle tie is not flagged.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt + CNT_W'(1);
        w_quiet_next    = r_quiet;
        w_img_next      = r_img;
        w_dto_next      = r_dto;
        w_quiet_done    = !spi_busy && (r_quiet == QUIET_LAST);
        w_drain_expired = (r_cnt == DRAIN_LAST);
        case (r_state)
            S_IDLE: begin
                w_cnt_next   = '0;
                w_quiet_next = '0;
                if (boot_req) begin
                    w_state_next = S_DRAIN;
                    w_img_next   = image_sel;
                end
            end
            S_DRAIN: begin
                w_quiet_next = spi_busy ? '0 : r_quiet + Q_W'(1);
                if (w_quiet_done || w_drain_expired) begin
                    w_state_next = S_DETACH;
                    w_cnt_next   = '0;
                    w_quiet_next = '0;
                    if (!w_quiet_done) w_dto_next = 1'b1;
                end
            end
            S_DETACH: begin
                if (r_cnt == DETACH_LAST) begin
                    w_state_next = S_ARM;
                    w_cnt_next   = '0;
                end
            end
            S_ARM: begin
                if (r_cnt == ARM_LAST) begin
                    w_state_next = S_FIRE;
                    w_cnt_next   = '0;
                end
            end
            S_FIRE: begin
                w_cnt_next = r_cnt;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign spi_hold      = (r_state != S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign usb_pu        = usb_pu_en && ((r_state == S_IDLE) || (r_state == S_DRAIN));
    assign wb_boot       = (r_state == S_FIRE);
    assign wb_s1         = r_img[1];
    assign wb_s0         = r_img[0];
    assign drain_timeout = r_dto;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Directed bench for warmboot_sequencer: quiesce, glitchy drain, drain timeout,
// ignored re-requests, and reset abort mid-detach followed by a replay.
module tb_warmboot_sequencer;

    localparam int QC = 4;
    localparam int DT = 50;
    localparam int DC = 100;
    localparam int AC = 4;

    logic       clk_48mhz = 1'b0;
    logic       reset     = 1'b1;
    logic       boot_req  = 1'b0;
    logic [1:0] image_sel = 2'b00;
    logic       spi_busy  = 1'b0;
    logic       usb_pu_en = 1'b1;
    logic       spi_hold, usb_pu, wb_s1, wb_s0, wb_boot, busy, drain_timeout;

    int n_vec = 0;
    int n_err = 0;

    typedef enum int {P_IDLE, P_DRAIN, P_DET, P_ARM, P_FIRE} phase_t;

    warmboot_sequencer #(
        .QUIESCE_CYCLES(QC),
        .DRAIN_TIMEOUT (DT),
        .DETACH_CYCLES (DC),
        .ARM_CYCLES    (AC)
    ) dut (
        .clk_48mhz    (clk_48mhz),
        .reset        (reset),
        .boot_req     (boot_req),
        .image_sel    (image_sel),
        .spi_busy     (spi_busy),
        .spi_hold     (spi_hold),
        .usb_pu_en    (usb_pu_en),
        .usb_pu       (usb_pu),
        .wb_s1        (wb_s1),
        .wb_s0        (wb_s0),
        .wb_boot      (wb_boot),
        .busy         (busy),
        .drain_timeout(drain_timeout)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic check(input string tag, input phase_t ph, input logic [1:0] img, input logic dto);
        logic [6:0] exp_v, obs_v;
        exp_v = {ph != P_IDLE, ph != P_IDLE, usb_pu_en && (ph == P_IDLE || ph == P_DRAIN),
                 img, ph == P_FIRE, dto};
        obs_v = {spi_hold, busy, usb_pu, wb_s1, wb_s0, wb_boot, drain_timeout};
        n_vec++;
        assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (hold busy pu s1 s0 boot dto)", tag, obs_v, exp_v);
        end
    endtask

    // Expected phase t edges after the request edge, given d cycles spent in DRAIN.
    function automatic phase_t seq_phase(input int t, input int d);
        if (t <= d)           return P_DRAIN;
        if (t <= d + DC)      return P_DET;
        if (t <= d + DC + AC) return P_ARM;
        return P_FIRE;
    endfunction

    // mode 0: spi idle; 1: busy 7 cycles then a one-cycle glitch; 2: spi stuck busy.
    task automatic run_seq(input string tag, input logic [1:0] img, input int d,
                           input int mode, input int stop_t);
        image_sel = img;
        boot_req  = 1'b1;
        for (int t = 1; t <= stop_t; t++) begin
            spi_busy = (mode == 1) ? (t <= 8 || t == 11) : (mode == 2);
            tick();
            boot_req = 1'b0;
            check(tag, seq_phase(t, d), img, (mode == 2) && (t > d));
            if (t == 30) begin
                image_sel = ~img;
                boot_req  = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input string tag);
        reset    = 1'b1;
        spi_busy = 1'b0;
        boot_req = 1'b0;
        #2;
        check(tag, P_IDLE, 2'b00, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check(tag, P_IDLE, 2'b00, 1'b0);
    endtask

    initial begin
        #12;
        check("reset_hold", P_IDLE, 2'b00, 1'b0);
        usb_pu_en = 1'b0;
        #1;
        check("reset_pu_off", P_IDLE, 2'b00, 1'b0);
        usb_pu_en = 1'b1;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 200; i++) begin
            usb_pu_en = (i % 50 != 7);
            image_sel = 2'(i);
            tick();
            check("idle", P_IDLE, 2'b00, 1'b0);
        end
        usb_pu_en = 1'b1;

        run_seq("quiesce", 2'b10, QC, 0, 130);
        do_reset("reset_a");
        run_seq("glitch", 2'b11, 14, 1, 130);
        do_reset("reset_b");
        run_seq("timeout", 2'b01, DT, 2, 170);
        do_reset("reset_c");

        // Abort at DETACH cycle 60, away from a clock edge.
        run_seq("abort", 2'b11, QC, 0, QC + 60);
        #3;
        reset = 1'b1;
        #1;
        check("abort_rst", P_IDLE, 2'b00, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check("abort_idle", P_IDLE, 2'b00, 1'b0);
        run_seq("replay", 2'b01, QC, 0, 120);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
